// File: rtl/visumon_debug_arbiter_pkg.sv
// rtl/visumon_debug_arbiter_pkg.sv - debug-LED payload types and defaults shared by the visuMon debug path
package visumon_debug_arbiter_pkg;

    localparam int LED_COUNT_DEFAULT = 32;
    localparam int LED_NO_W          = 8;

    typedef enum logic [2:0] {
        COLOR_OFF,
        COLOR_RED,
        COLOR_GREEN,
        COLOR_BLUE,
        COLOR_YELLOW,
        COLOR_CYAN,
        COLOR_MAGENTA,
        COLOR_WHITE
    } color_t;

    typedef struct packed {
        logic [LED_NO_W-1:0] led_no;
        color_t              color;
        logic                status;
    } debug_info_t;

endpackage

// File: rtl/visumon_debug_arbiter_if.sv
// rtl/visumon_debug_arbiter_if.sv - requester-side request/ack bundle plus the visuMon write strobe
interface visumon_debug_arbiter_if
    import visumon_debug_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    logic        [NUM_REQ-1:0] i_req;
    debug_info_t [NUM_REQ-1:0] i_debugInfo;
    logic        [NUM_REQ-1:0] o_ack;
    logic                      o_err;
    logic                      o_cs;
    debug_info_t               o_debugInfo;
    logic                      o_busy;

    modport master (
        output i_req, i_debugInfo,
        input  o_ack, o_err, o_cs, o_debugInfo, o_busy
    );

    modport slave (
        input  i_req, i_debugInfo,
        output o_ack, o_err, o_cs, o_debugInfo, o_busy
    );
endinterface

// File: rtl/visumon_rr_arbiter.sv
// rtl/visumon_rr_arbiter.sv - combinational round-robin pick: first request at or after ptr, wrapping
module visumon_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PW-1:0]      idx,
    output logic               any
);
    logic          found;
    logic [PW:0]   sum;
    logic [PW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        any   = |req;
        for (int i = 0; i < NUM_REQ; i++) begin
            // One spare bit keeps ptr+i from overflowing before the modulo wrap.
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(NUM_REQ)) begin
                sum = sum - (PW+1)'(NUM_REQ);
            end
            cand = sum[PW-1:0];
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end
endmodule

// File: rtl/visumon_debug_arbiter.sv
// rtl/visumon_debug_arbiter.sv - round-robin funnel of debug-LED updates into visuMon's chip-select write port
module visumon_debug_arbiter
    import visumon_debug_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int CS_CYCLES  = 1,
    parameter int GAP_CYCLES = 2,
    parameter int LED_COUNT  = LED_COUNT_DEFAULT
) (
    input  logic                   i_clk25Mhz,
    input  logic                   i_reset,
    visumon_debug_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_GAP
    } state_t;

    localparam int PW   = $clog2(NUM_REQ);
    localparam int CMAX = (CS_CYCLES > GAP_CYCLES) ? CS_CYCLES : GAP_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] CS_LAST  = CW'(CS_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
    localparam state_t        AFTER_CS = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

    state_t               state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    debug_info_t          payload_q, payload_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 err_q, err_d;
    logic                 cs_q, cs_d;
    logic                 busy_q, busy_d;

    logic [NUM_REQ-1:0]   grant;
    logic [PW-1:0]        grant_idx;
    logic                 grant_any;
    debug_info_t          gnt_info;
    logic                 in_range;
    logic [PW-1:0]        ptr_next;

    visumon_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_rr (
        .req   (bus.i_req),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    assign gnt_info = bus.i_debugInfo[grant_idx];
    assign in_range = int'(gnt_info.led_no) < LED_COUNT;
    assign ptr_next = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        payload_d = payload_q;
        ack_d     = '0;
        err_d     = 1'b0;
        cs_d      = cs_q;
        case (state_q)
            ST_IDLE: begin
                cs_d = 1'b1;
                if (grant_any) begin
                    payload_d = gnt_info;
                    ptr_d     = ptr_next;
                    ack_d     = grant;
                    cnt_d     = '0;
                    if (in_range) begin
                        state_d = ST_WRITE;
                        cs_d    = 1'b0;
                    end else begin
                        // Out-of-range LEDs are acked and dropped; the gap still applies.
                        err_d   = 1'b1;
                        state_d = AFTER_CS;
                    end
                end
            end
            ST_WRITE: begin
                if (cnt_q == CS_LAST) begin
                    cnt_d   = '0;
                    cs_d    = 1'b1;
                    state_d = AFTER_CS;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cs_d    = 1'b1;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk25Mhz or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            payload_q <= '0;
            ack_q     <= '0;
            err_q     <= 1'b0;
            cs_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            payload_q <= payload_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            cs_q      <= cs_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.o_ack       = ack_q;
    assign bus.o_err       = err_q;
    assign bus.o_cs        = cs_q;
    assign bus.o_debugInfo = payload_q;
    assign bus.o_busy      = busy_q;
endmodule

// File: tb/tb_visumon_debug_arbiter.sv
// tb/tb_visumon_debug_arbiter.sv - directed and randomized bench against a transaction-level arbiter model
module tb_visumon_debug_arbiter;
    import visumon_debug_arbiter_pkg::*;

    localparam int N    = 4;
    localparam int CS   = 1;
    localparam int GAP  = 2;
    localparam int LEDS = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #20 clk = ~clk;

    visumon_debug_arbiter_if #(.NUM_REQ(N)) bus ();

    visumon_debug_arbiter #(
        .NUM_REQ    (N),
        .CS_CYCLES  (CS),
        .GAP_CYCLES (GAP),
        .LED_COUNT  (LEDS)
    ) dut (
        .i_clk25Mhz (clk),
        .i_reset    (rst_n),
        .bus        (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Model: remaining busy/cs cycles after a grant, plus the round-robin pointer.
    int          m_ptr;
    int          m_busy_left;
    int          m_cs_left;
    logic [N-1:0] m_ack;
    logic        m_err;
    debug_info_t m_info;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_ptr       = 0;
        m_busy_left = 0;
        m_cs_left   = 0;
        m_ack       = '0;
        m_err       = 1'b0;
        m_info      = '0;
    endfunction

    function automatic void model_edge();
        int g;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_ack = '0;
        m_err = 1'b0;
        if (m_busy_left == 0 && bus.i_req != '0) begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && bus.i_req[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
            m_ptr    = (g + 1) % N;
            m_ack[g] = 1'b1;
            m_info   = bus.i_debugInfo[g];
            if (int'(m_info.led_no) < LEDS) begin
                m_cs_left   = CS;
                m_busy_left = CS + GAP;
            end else begin
                m_err       = 1'b1;
                m_cs_left   = 0;
                m_busy_left = GAP;
            end
        end else begin
            if (m_busy_left > 0) m_busy_left--;
            if (m_cs_left > 0) m_cs_left--;
        end
    endfunction

    task automatic check_outputs();
        check("ack",  32'(bus.o_ack), 32'(m_ack));
        check("err",  32'(bus.o_err), 32'(m_err));
        check("cs",   32'(bus.o_cs), (m_cs_left > 0) ? 32'd0 : 32'd1);
        check("busy", 32'(bus.o_busy), (m_busy_left > 0) ? 32'd1 : 32'd0);
        check("info", 32'(bus.o_debugInfo), 32'(m_info));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        check_outputs();
    endtask

    function automatic debug_info_t rand_info(input int max_led);
        debug_info_t d;
        d.led_no = 8'($urandom_range(0, max_led));
        d.color  = color_t'($urandom_range(0, 7));
        d.status = 1'($urandom_range(0, 1));
        return d;
    endfunction

    function automatic int ack_index(input logic [N-1:0] a);
        int r = -1;
        for (int k = 0; k < N; k++) if (a[k]) r = k;
        return r;
    endfunction

    task automatic idle_out(input int cycles);
        bus.i_req = '0;
        repeat (cycles) step();
    endtask

    initial begin
        int cs_low, busy_cnt, ack_cnt, last_idx, last_cyc, idx;
        bit found;

        model_reset();
        bus.i_req = '0;
        for (int k = 0; k < N; k++) bus.i_debugInfo[k] = rand_info(40);

        // Reset held with all requests pending.
        rst_n = 1'b0;
        bus.i_req = 4'hF;
        repeat (20) step();
        rst_n = 1'b1;
        idle_out(2);

        // Single write from requester 0.
        bus.i_debugInfo[0] = '{led_no: 8'd20, color: COLOR_BLUE, status: 1'b1};
        bus.i_req[0] = 1'b1;
        cs_low = 0; busy_cnt = 0; ack_cnt = 0;
        repeat (6) begin
            step();
            if (m_ack[0]) bus.i_req[0] = 1'b0;
            if (bus.o_cs == 1'b0) cs_low++;
            if (bus.o_busy) busy_cnt++;
            if (bus.o_ack == 4'b0001) ack_cnt++;
        end
        check("single_cs_low", 32'(cs_low), 32'd1);
        check("single_busy", 32'(busy_cnt), 32'd3);
        check("single_ack", 32'(ack_cnt), 32'd1);

        // Fairness: all four held, then 1010.
        for (int k = 0; k < N; k++) bus.i_debugInfo[k] = rand_info(LEDS - 1);
        bus.i_req = 4'hF;
        last_idx = -1; last_cyc = 0;
        repeat (24) begin
            step();
            for (int k = 0; k < N; k++) if (m_ack[k]) bus.i_debugInfo[k] = rand_info(LEDS - 1);
            idx = ack_index(bus.o_ack);
            if (idx >= 0) begin
                if (last_idx >= 0) begin
                    check("fair_order", 32'(idx), 32'((last_idx + 1) % N));
                    check("fair_spacing", 32'(cyc - last_cyc), 32'(CS + GAP + 1));
                end
                last_idx = idx; last_cyc = cyc;
            end
        end
        bus.i_req = 4'b1010;
        last_idx = -1;
        repeat (20) begin
            step();
            idx = ack_index(bus.o_ack);
            if (idx >= 0) begin
                if (last_idx >= 0) check("alt_order", 32'(idx), (last_idx == 1) ? 32'd3 : 32'd1);
                last_idx = idx;
            end
        end
        idle_out(5);

        // Range boundary on requester 2.
        bus.i_debugInfo[2] = '{led_no: 8'(LEDS), color: COLOR_RED, status: 1'b0};
        bus.i_req[2] = 1'b1;
        cs_low = 0; found = 0;
        repeat (5) begin
            step();
            if (m_ack[2]) bus.i_req[2] = 1'b0;
            if (bus.o_cs == 1'b0) cs_low++;
            if (bus.o_err && bus.o_ack == 4'b0100) found = 1;
        end
        check("range_err_ack", 32'(found), 32'd1);
        check("range_no_write", 32'(cs_low), 32'd0);
        bus.i_debugInfo[2] = '{led_no: 8'(LEDS - 1), color: COLOR_GREEN, status: 1'b1};
        bus.i_req[2] = 1'b1;
        cs_low = 0;
        repeat (5) begin
            step();
            if (m_ack[2]) bus.i_req[2] = 1'b0;
            if (bus.o_cs == 1'b0) cs_low++;
        end
        check("range_last_write", 32'(cs_low), 32'd1);
        idle_out(3);

        // Reset asserted while requester 1 is writing.
        bus.i_debugInfo[1] = rand_info(LEDS - 1);
        bus.i_req[1] = 1'b1;
        found = 0;
        for (int t = 0; t < 8 && !found; t++) begin
            step();
            if (bus.o_cs == 1'b0) found = 1;
        end
        check("midop_reached_write", 32'(found), 32'd1);
        #5;
        rst_n = 1'b0;
        #1;
        check("midop_async_cs", 32'(bus.o_cs), 32'd1);
        check("midop_async_busy", 32'(bus.o_busy), 32'd0);
        model_reset();
        bus.i_req = 4'hF;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("midop_first_grant", 32'(bus.o_ack), 32'd1);
        idle_out(5);

        // Withdraw: requester 2 raised while busy and dropped before IDLE.
        bus.i_debugInfo[0] = rand_info(LEDS - 1);
        bus.i_req[0] = 1'b1;
        cs_low = 0; ack_cnt = 0;
        for (int t = 0; t < 9; t++) begin
            step();
            if (bus.o_cs == 1'b0) cs_low++;
            if (bus.o_ack[2]) ack_cnt++;
            if (t == 0) begin
                bus.i_req[0] = 1'b0;
                bus.i_req[2] = 1'b1;
            end
            if (t == 1) bus.i_req[2] = 1'b0;
        end
        check("withdraw_one_write", 32'(cs_low), 32'd1);
        check("withdraw_no_ack", 32'(ack_cnt), 32'd0);

        // Randomized traffic with occasional resets.
        for (int t = 0; t < 3000; t++) begin
            step();
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
            for (int k = 0; k < N; k++) begin
                if (m_ack[k]) begin
                    if ($urandom_range(0, 2) == 0) bus.i_debugInfo[k] = rand_info(40);
                    else bus.i_req[k] = 1'b0;
                end else if (bus.i_req[k]) begin
                    if ($urandom_range(0, 19) == 0) bus.i_req[k] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    bus.i_debugInfo[k] = rand_info(40);
                    bus.i_req[k] = 1'b1;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
